// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/operand/result bundle between control FSM and mult/div unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             MultStart;
    logic             DivStart;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output MultStart, DivStart, A, B,
        input  Hi, Lo, Busy, Done, DivZero
    );

    modport slave (
        input  MultStart, DivStart, A, B,
        output Hi, Lo, Busy, Done, DivZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed radix-2 Booth multiply / restoring divide into Hi/Lo
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_unit_if.slave        bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DIVFIX,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             last_iter;

    // Acc and M are one bit wider than the operands so -2^(W-1) terms stay exact.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
    end

    assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_trial = div_shift - m_q;
    assign a_abs     = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_abs     = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.MultStart) begin
                    acc_d   = '0;
                    q_d     = bus.B;
                    qm1_d   = 1'b0;
                    m_d     = {bus.A[WIDTH-1], bus.A};
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_MULT;
                end else if (bus.DivStart) begin
                    if (bus.B == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        acc_d     = '0;
                        q_d       = a_abs;
                        m_d       = {1'b0, b_abs};
                        neg_quo_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        neg_rem_d = bus.A[WIDTH-1];
                        cnt_d     = '0;
                        dz_d      = 1'b0;
                        state_d   = S_DIV;
                    end
                end
            end
            S_MULT: begin
                acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = S_FINISH;
            end
            S_DIV: begin
                // Quotient bits shift into q_q as dividend bits shift out of it.
                if (!div_trial[WIDTH]) begin
                    acc_d = div_trial;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = S_DIVFIX;
            end
            S_DIVFIX: begin
                q_d     = neg_quo_q ? -q_q : q_q;
                acc_d   = {1'b0, (neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])};
                state_d = S_FINISH;
            end
            S_FINISH: begin
                if (!dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                end
                done_d    = 1'b1;
                divzero_d = dz_q;
                dz_d      = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.Busy    = (state_q != S_IDLE);
    assign bus.Done    = done_q;
    assign bus.DivZero = divzero_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ms;
        logic        ds;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                          output int lat, output int busy_bad, output logic busy_at_done);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.MultStart = ms; bus.DivStart = ds;
        @(negedge clk);
        bus.MultStart = 1'b0; bus.DivStart = 1'b0;
        lat = -1; busy_bad = 0; busy_at_done = 1'bx;
        if (!bus.Busy || bus.Done) busy_bad++;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.Done) begin
                lat = n;
                busy_at_done = bus.Busy;
                break;
            end
            if (!bus.Busy) busy_bad++;
        end
        hi = bus.Hi; lo = bus.Lo; dz = bus.DivZero;
    endtask

    logic [31:0] hi, lo;
    logic        dz, bad_busy_done;
    int          lat, busy_bad, dones;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[2]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[3]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[4]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[6]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1};
        vecs[7]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
        vecs[8]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFD, 32'd1,        32'hFFFFFFFE, 1'b0, 34};
        vecs[10] = '{1'b1, 1'b1, 32'd6,        32'd4,        32'd0,        32'd24,       1'b0, 33};

        bus.MultStart = 1'b0; bus.DivStart = 1'b0; bus.A = '0; bus.B = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.Hi, 0);
        check("reset_lo", bus.Lo, 0);
        check("reset_busy", bus.Busy, 0);
        check("reset_done", bus.Done, 0);
        check("reset_divzero", bus.DivZero, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].ms, vecs[i].ds, vecs[i].a, vecs[i].b, hi, lo, dz, lat, busy_bad, bad_busy_done);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_divzero", i), dz, vecs[i].dz);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_gaps", i), busy_bad, 0);
            check($sformatf("v%0d_busy_at_done", i), bad_busy_done, 0);
        end

        // DivStart mid-multiply must be ignored: exactly one Done, the multiply result.
        @(negedge clk);
        bus.A = 32'd9; bus.B = 32'hFFFFFFFE; bus.MultStart = 1'b1;
        @(negedge clk);
        bus.MultStart = 1'b0;
        dones = 0; dz = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (n == 5) begin bus.A = 32'd100; bus.B = 32'd7; bus.DivStart = 1'b1; end
            if (n == 6) bus.DivStart = 1'b0;
            @(negedge clk);
            if (bus.Done) begin
                dones++;
                hi = bus.Hi; lo = bus.Lo;
            end
            if (bus.DivZero) dz = 1'b1;
        end
        check("mid_div_done_count", dones, 1);
        check("mid_div_hi", hi, 32'hFFFFFFFF);
        check("mid_div_lo", lo, 32'hFFFFFFEE);
        check("mid_div_divzero", dz, 0);

        // Reset 10 cycles into a multiply aborts at once with no Done.
        @(negedge clk);
        bus.A = 32'h1234; bus.B = 32'h10; bus.MultStart = 1'b1;
        @(negedge clk);
        bus.MultStart = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi", bus.Hi, 0);
        check("abort_lo", bus.Lo, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) dones++;
        end
        check("abort_no_done", dones, 0);

        run_op(1'b1, 1'b0, 32'd3, 32'd5, hi, lo, dz, lat, busy_bad, bad_busy_done);
        check("post_reset_lo", lo, 32'd15);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_latency", lat, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
